// File: rtl/apb_fifo_completer.sv
// apb_fifo_completer -- APB completer fronting a TX (bus->local) and an RX
// (local->bus) 32-bit FIFO behind a 32-byte register window.
//
// Ports:
//   PCLK, PRESETn          clock, async active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB request
//   PRDATA/PREADY/PSLVERR  APB response (PRDATA/PSLVERR zero unless PREADY)
//   tx_data/tx_valid/tx_ready   TX FIFO head, first-word fall-through
//   rx_data/rx_valid/rx_ready   RX FIFO push side
//   irq                    (CTRL[0] & tx_empty) | (CTRL[1] & !rx_empty)
//
// Registers (offset PADDR[4:2]*4): 0x00 TXDATA (W), 0x04 RXDATA (R, pops),
// 0x08 STATUS (R), 0x0C CTRL (R/W, bits [3:2] are write-1 flush strobes).

// Circular FIFO. The parent guarantees no push when full and no pop when
// empty, so the count never over/underflows.
module apb_fifo_completer_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            // flush wins over any same-cycle push or pop
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge PCLK) begin
        if (push && !flush) mem[wp] <= wdata;
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // Head is forced to zero when empty so the output is defined from reset.
    assign rdata = empty ? '0 : mem[rp];
endmodule

module apb_fifo_completer #(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          DEPTH       = 8,
    parameter int          WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);
    localparam int         AW = $clog2(DEPTH);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state, state_nxt;
    logic [2:0]  wcnt;
    logic [1:0]  ctrl;
    logic        in_win, err, done;
    logic [2:0]  off;
    logic [31:0] rdata, status, rx_head;
    logic        tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic        ctrl_wr;
    logic [AW:0] tx_count, rx_count;
    logic        unused_paddr;

    // Byte lanes within a word are not decoded.
    assign unused_paddr = &{1'b0, PADDR[1:0]};

    // Bus-phase tracker; it lags the bus by one cycle, so PREADY only needs
    // it to reject an enable phase that had no setup phase since reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (PSEL && !PENABLE) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (!PSEL)            state_nxt = IDLE;
                     else if (!PENABLE)    state_nxt = SETUP;
            default: state_nxt = IDLE;
        endcase
    end

    assign PREADY = PSEL && PENABLE && (state != IDLE) && (wcnt == WS);
    assign done   = PREADY;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                                 wcnt <= '0;
        else if (!PSEL || done)                       wcnt <= '0;
        else if (PENABLE && state != IDLE && wcnt != WS) wcnt <= wcnt + 1'b1;
    end

    // Address decode / error decision from the registered FIFO state.
    assign in_win = (PADDR[31:5] == BASE_ADDR[31:5]);
    assign off    = PADDR[4:2];
    assign status = {12'b0, 4'(rx_count), 4'b0, 4'(tx_count),
                     4'b0, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        err   = 1'b1;
        rdata = '0;
        if (in_win) begin
            case (off)
                3'd0: err = !PWRITE || tx_full;
                3'd1: begin err = PWRITE || rx_empty; rdata = rx_head; end
                3'd2: begin err = PWRITE;             rdata = status;  end
                3'd3: begin err = 1'b0;               rdata = {30'b0, ctrl}; end
                default: err = 1'b1;
            endcase
        end
    end

    assign PSLVERR = done && err;
    assign PRDATA  = (done && !err && !PWRITE) ? rdata : '0;

    assign tx_push  = done && !err && PWRITE  && off == 3'd0;
    assign rx_pop   = done && !err && !PWRITE && off == 3'd1;
    assign ctrl_wr  = done && !err && PWRITE  && off == 3'd3;
    assign tx_flush = ctrl_wr && PWDATA[2];
    assign rx_flush = ctrl_wr && PWDATA[3];
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)     ctrl <= '0;
        else if (ctrl_wr) ctrl <= PWDATA[1:0];
    end

    apb_fifo_completer_fifo #(.DEPTH(DEPTH)) u_tx (
        .PCLK(PCLK), .PRESETn(PRESETn), .push(tx_push), .pop(tx_pop),
        .flush(tx_flush), .wdata(PWDATA), .rdata(tx_data), .count(tx_count),
        .full(tx_full), .empty(tx_empty)
    );

    apb_fifo_completer_fifo #(.DEPTH(DEPTH)) u_rx (
        .PCLK(PCLK), .PRESETn(PRESETn), .push(rx_push), .pop(rx_pop),
        .flush(rx_flush), .wdata(rx_data), .rdata(rx_head), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign irq      = (ctrl[0] && tx_empty) || (ctrl[1] && !rx_empty);
endmodule

// File: doc/apb_fifo_completer.md
# apb_fifo_completer

APB completer that fronts a pair of 32-bit FIFOs (TX: bus → local, RX: local → bus) behind a memory-mapped register window. It inserts a fixed, programmable number of wait states and reports errors through PSLVERR. It is the responder counterpart to our `apb_master` initiator and is the peripheral template for streaming blocks such as UART or SPI data paths. It extends the basic register-file slave with wait states, error responses, side-effecting reads, and local valid/ready handshakes.

## Interface
Parameters:
- BASE_ADDR, 32'h2000_0000: 32-byte window base; PADDR[31:5] must match BASE_ADDR[31:5].
- DEPTH, 8: entries per FIFO; legal values are 2, 4 and 8.
- WAIT_STATES, 1: wait cycles with PREADY=0 inserted per access; legal range 0..7.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  32  byte address.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid only when PREADY=1, otherwise 0.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response; valid only when PREADY=1, otherwise 0.
- tx_data  out  32  TX FIFO head (first-word fall-through).
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  local consumer pops TX when tx_valid & tx_ready.
- rx_data  in  32  local producer data.
- rx_valid  in  1  RX push request.
- rx_ready  out  1  RX FIFO not full.
- irq  out  1  (CTRL[0] & tx_empty) | (CTRL[1] & !rx_empty).

## Operation
Register map (offset = PADDR[4:2]×4; accesses outside the window or to offsets 0x10–0x1C give PSLVERR=1, PRDATA=0, no side effect):
- 0x00 TXDATA, write-only. A write pushes PWDATA. A write when TX is full gives PSLVERR and no push. A read gives PSLVERR.
- 0x04 RXDATA, read-only. A read returns the head and pops it. A read when RX is empty gives PSLVERR, PRDATA=0, no pop. A write gives PSLVERR.
- 0x08 STATUS, read-only. Bit fields:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
  - [11:8] tx_count, [19:16] rx_count; all other bits 0.
  - A write gives PSLVERR.
- 0x0C CTRL, read/write. Bit fields:
  - [0] tx_irq_en, [1] rx_irq_en.
  - [2] tx_flush, [3] rx_flush: write-1 self-clearing; the flush happens on the completing cycle.
  - Reads return [1:0]; all other bits read 0.

FSM (3 states):
- IDLE: PSEL=0. IDLE→SETUP on PSEL & !PENABLE.
- SETUP: SETUP→ACCESS on the next cycle.
- ACCESS: wait counter wcnt increments on each cycle with PSEL & PENABLE.
  - PREADY = PSEL & PENABLE & (wcnt == WAIT_STATES).
  - On PREADY the FSM goes to SETUP if PSEL & !PENABLE follows (back-to-back); otherwise it returns to IDLE.
  - wcnt clears on completion and whenever PSEL=0.
- Side effects (push, pop, CTRL write, flush) occur only on the completing cycle (PSEL & PENABLE & PREADY).
- The error decision and read data use the FIFO state registered at the start of the completing cycle.

FIFO rules:
- Circular buffers with log2(DEPTH)-bit pointers that wrap at DEPTH; counts are log2(DEPTH)+1 bits wide.
- A simultaneous push and pop on the same FIFO leaves the count unchanged.
- Push when full is an error even if a local pop happens in the same cycle.
- Pop when empty is an error even if a local push happens in the same cycle; the pushed entry is kept.
- Flush overrides a same-cycle local pop or push: the count becomes 0 and the pointers become equal.
- rx_valid while rx_ready=0 is ignored and the data is dropped.

## Timing
- Reset values:
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - tx_valid=0, tx_data=0, rx_ready=1, irq=0.
  - CTRL=0, both FIFOs empty, FSM=IDLE, wcnt=0.
- Reset mid-transfer aborts the transfer with no side effects.
- Access latency: SETUP (1 cycle) + WAIT_STATES cycles with PREADY=0 + 1 cycle with PREADY=1. With WAIT_STATES=0, PREADY=1 on the first ACCESS cycle.
- tx_valid, rx_ready, STATUS and irq reflect a push, pop or flush on the clock edge after the completing cycle.
- rx_data is captured on the clock edge where rx_valid & rx_ready.

## Test plan
- **Write with wait states.** WAIT_STATES=2, write 0xDEADBEEF to 0x2000_0000 with tx_ready=0. Expect PREADY=0 for 2 ACCESS cycles, then 1 with PSLVERR=0. On the next cycle tx_valid=1 and tx_data=0xDEADBEEF.
- **TX fill and overflow.** Push 8 words 0x1..0x8, then push 0x9. Expect STATUS=0x0000_0809 (tx_count=8, tx_full, rx_empty) and PSLVERR=1 on the ninth write. Then drain with tx_ready=1 and expect order 1..8.
- **RX pop order and underflow.** Drive rx_valid with 0xA5A5_0001 and 0xA5A5_0002. Read 0x04 three times: expect data in that order, then PSLVERR=1 with PRDATA=0 on the third read; STATUS afterwards reads 0x0000_000A.
- **Address errors.** Access 0x2000_0010, 0x3000_0000, write STATUS, and read TXDATA. Expect PSLVERR=1 on each with no state change.
- **Flush and interrupts.** With TX holding 3 words and an RX push occurring in the same cycle as the CTRL write, write CTRL=0x0000_000F. Expect both counts 0, CTRL to read back 0x3, and irq=1 (TX empty) one cycle later.
- **Simultaneous push/pop and reset.** An APB push in the same cycle as a local pop with count 4 leaves count 4. Asserting PRESETn=0 during a wait state returns all outputs to their reset values and leaves the FIFOs empty.
